uart_cmd_rx: RTL and testbench

Serial command input for the pet core. It samples the host's `uart_rx` line and rebuilds 8N1 bytes at a fixed baud rate. It then parses short ASCII command lines (for example "F\r" or "E12\n") into one-cycle command strobes with a code and a small argument. These strobes feed the pet state logic. It is the receive-side counterpart of the status-dump transmitter, and its report command triggers that dump.

---
 rtl/uart_cmd_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver with an ASCII command-line parser that emits one-cycle
// command strobes (code + small decimal argument) for the pet state logic.
module uart_cmd_rx #(
    parameter int unsigned DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] cmd_arg,
    output logic       cmd_error
);

    localparam int unsigned       CNT_W     = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [7:0]        CHAR_CR   = 8'h0D;
    localparam logic [7:0]        CHAR_LF   = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxs;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_byte;
    logic             r_rx_valid;
    logic             r_frame_err;

    logic [1:0]       r_chars;
    logic [2:0]       r_code;
    logic [6:0]       r_acc;
    logic             r_bad;
    logic             r_cmd_valid;
    logic             r_cmd_error;
    logic [2:0]       r_cmd_code;
    logic [4:0]       r_cmd_arg;

    logic [7:0]       w_upper;
    logic             w_is_term;
    logic             w_is_digit;
    logic [2:0]       w_code;
    logic [6:0]       w_acc_next;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Bit-level receiver; the stop bit is judged at mid-bit so back-to-back frames work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_rx_valid <= 1'b1;
                            r_rx_byte  <= r_shift;
                            r_state    <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Character classification of the byte just received.
    always_comb begin
        w_upper = r_rx_byte;
        if (r_rx_byte >= 8'h61 && r_rx_byte <= 8'h7A) begin
            w_upper = r_rx_byte - 8'h20;
        end
        w_is_term  = (r_rx_byte == CHAR_CR) || (r_rx_byte == CHAR_LF);
        w_is_digit = (w_upper >= 8'h30) && (w_upper <= 8'h39);
        w_code     = 3'd0;
        case (w_upper)
            8'h46:        w_code = 3'd1;
            8'h50:        w_code = 3'd2;
            8'h43:        w_code = 3'd3;
            8'h53:        w_code = 3'd4;
            8'h57:        w_code = 3'd5;
            8'h52, 8'h3F: w_code = 3'd6;
            8'h45:        w_code = 3'd7;
            default:      w_code = 3'd0;
        endcase
        w_acc_next = 7'(r_acc * 7'd10 + 7'(w_upper[3:0]));
    end

    // Line parser; a framing error occupies a character slot and poisons the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chars     <= '0;
            r_code      <= '0;
            r_acc       <= '0;
            r_bad       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_error <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_arg   <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_error <= 1'b0;
            if (r_frame_err) begin
                r_bad <= 1'b1;
                if (r_chars != 2'd3) begin
                    r_chars <= r_chars + 2'd1;
                end
            end else if (r_rx_valid) begin
                if (w_is_term) begin
                    if (r_chars != 2'd0) begin
                        if (r_bad) begin
                            r_cmd_error <= 1'b1;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_code  <= r_code;
                            r_cmd_arg   <= (r_acc > 7'd31) ? 5'd31 : r_acc[4:0];
                        end
                        r_chars <= '0;
                        r_code  <= '0;
                        r_acc   <= '0;
                        r_bad   <= 1'b0;
                    end
                end else begin
                    case (r_chars)
                        2'd0: begin
                            r_code <= w_code;
                            if (w_code == 3'd0) begin
                                r_bad <= 1'b1;
                            end
                        end
                        2'd1, 2'd2: begin
                            if (w_is_digit) begin
                                r_acc <= w_acc_next;
                            end else begin
                                r_bad <= 1'b1;
                            end
                        end
                        default: r_bad <= 1'b1;
                    endcase
                    if (r_chars != 2'd3) begin
                        r_chars <= r_chars + 2'd1;
                    end
                end
            end
        end
    end

    assign rx_byte   = r_rx_byte;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_arg   = r_cmd_arg;
    assign cmd_error = r_cmd_error;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: directed lines plus random command lines,
// checked against a whole-line reference model.
module tb_uart_cmd_rx;

    localparam int unsigned D = 16;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef struct packed {
        logic       err;
        logic [7:0] b;
    } rx_exp_t;

    typedef struct packed {
        logic       err;
        logic [2:0] code;
        logic [4:0] arg;
    } cmd_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic [4:0] cmd_arg;
    logic       cmd_error;

    uart_cmd_rx #(.DELAY_FRAMES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_arg   (cmd_arg),
        .cmd_error (cmd_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rx_exp_t    rx_q[$];
    cmd_exp_t   cmd_q[$];
    logic [7:0] line_buf[$];
    bit         line_fe = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_ev = 0;
    int unsigned t_fall = 0;
    logic [2:0] last_code = 3'd0;
    logic [4:0] last_arg = 5'd0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
        case (u)
            "F":      return 3'd1;
            "P":      return 3'd2;
            "C":      return 3'd3;
            "S":      return 3'd4;
            "W":      return 3'd5;
            "R", "?": return 3'd6;
            "E":      return 3'd7;
            default:  return 3'd0;
        endcase
    endfunction

    // Whole-line reference: letter + up to two digits, nothing else, no framing error.
    function automatic cmd_exp_t model_line();
        cmd_exp_t r;
        bit       ok;
        int       val;
        ok  = !line_fe && (line_buf.size() <= 3) && (code_of(line_buf[0]) != 3'd0);
        val = 0;
        for (int i = 1; i < line_buf.size(); i++) begin
            if (line_buf[i] >= "0" && line_buf[i] <= "9") val = val * 10 + int'(line_buf[i] - "0");
            else ok = 1'b0;
        end
        r.err  = !ok;
        r.code = code_of(line_buf[0]);
        r.arg  = (val > 31) ? 5'd31 : 5'(val);
        return r;
    endfunction

    // Drives one frame; entered and left on a negedge so frames can abut exactly.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
        uart_rx = 1'b0;
        t_fall  = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(negedge clk);
            uart_rx = b[i];
        end
        repeat (D) @(negedge clk);
        uart_rx = stop_ok;
        repeat (D) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] b, input int gap);
        rx_q.push_back({1'b0, b});
        if (b == CR || b == LF) begin
            if (line_buf.size() > 0) begin
                cmd_q.push_back(model_line());
                line_buf.delete();
                line_fe = 1'b0;
            end
        end else begin
            line_buf.push_back(b);
        end
        send_byte(b, 1'b1, gap);
    endtask

    task automatic send_ferr(input logic [7:0] b);
        rx_q.push_back({1'b1, b});
        line_buf.push_back(b);
        line_fe = 1'b1;
        send_byte(b, 1'b0, 2 * D);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 0);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((rx_q.size() + cmd_q.size()) > 0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        check(name, rx_q.size() + cmd_q.size(), 0);
        rx_q.delete();
        cmd_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_valid"}, int'(rx_valid), 0);
        check({tag, "_rx_byte"}, int'(rx_byte), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        check({tag, "_cmd_code"}, int'(cmd_code), 0);
        check({tag, "_cmd_arg"}, int'(cmd_arg), 0);
        check({tag, "_cmd_error"}, int'(cmd_error), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT raises a strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && frame_err) check("rx_excl", 1, 0);
            if (cmd_valid && cmd_error) check("cmd_excl", 1, 0);
            if (rx_valid || frame_err) begin
                rx_exp_t e;
                int      lat;
                n_ev++;
                check("rx_expected", int'(rx_q.size() > 0), 1);
                if (rx_q.size() > 0) begin
                    e = rx_q.pop_front();
                    check("rx_kind_ferr", int'(frame_err), int'(e.err));
                    if (!e.err) check("rx_byte", int'(rx_byte), int'(e.b));
                    lat = int'(cyc - t_fall);
                    n_tests++;
                    if (lat < 154 || lat > 156) begin
                        n_fail++;
                        $display("FAIL rx_latency: got %0d cycles, expected 154..156", lat);
                    end
                end
            end
            if (cmd_valid || cmd_error) begin
                cmd_exp_t c;
                check("cmd_expected", int'(cmd_q.size() > 0), 1);
                if (cmd_q.size() > 0) begin
                    c = cmd_q.pop_front();
                    check("cmd_kind_err", int'(cmd_error), int'(c.err));
                    if (!c.err) begin
                        check("cmd_code", int'(cmd_code), int'(c.code));
                        check("cmd_arg", int'(cmd_arg), int'(c.arg));
                        last_code = c.code;
                        last_arg  = c.arg;
                    end else begin
                        check("cmd_code_hold", int'(cmd_code), int'(last_code));
                        check("cmd_arg_hold", int'(cmd_arg), int'(last_arg));
                    end
                end
            end
        end
    end

    initial begin
        string codes;
        int    ev0;
        codes   = "FPCSWR?E";
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_char(8'hA5, 20);
        send_line("\r");

        ev0 = n_ev;
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        check("glitch_no_event", n_ev - ev0, 0);

        send_line("f\r\n");
        send_line("E12\r");
        send_line("E99\r");
        send_line("X\r");
        send_line("P123\r");
        send_ferr(8'h46);
        send_line("\r");
        wait_drain("drain_directed");

        // Reset in the middle of data bit 4 of 'S', then abandon the frame.
        uart_rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (D) @(negedge clk);
            uart_rx = 8'h53 >> i;
        end
        repeat (D / 2) @(negedge clk);
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("midreset");
        rst = 1'b0;
        line_buf.delete();
        line_fe   = 1'b0;
        last_code = 3'd0;
        last_arg  = 5'd0;
        repeat (2 * D) @(negedge clk);
        send_line("W\r");
        wait_drain("drain_reset");

        for (int n = 0; n < 40; n++) begin
            int len;
            int t;
            len = $urandom_range(0, 4);
            for (int i = 0; i < len; i++) begin
                logic [7:0] c;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: begin
                        c = codes[$urandom_range(0, 7)];
                        if ($urandom_range(0, 1) == 1 && c != "?") c = c | 8'h20;
                        send_char(c, 0);
                    end
                    4, 5, 6, 7: begin
                        c = 8'h30 + 8'($urandom_range(0, 9));
                        send_char(c, 0);
                    end
                    8: begin
                        do c = 8'($urandom_range(0, 255)); while (c == CR || c == LF);
                        send_char(c, 0);
                    end
                    default: begin
                        do c = 8'($urandom_range(0, 255)); while (c == CR || c == LF);
                        send_ferr(c);
                    end
                endcase
            end
            t = $urandom_range(0, 2);
            if (t == 0) send_char(CR, 0);
            else if (t == 1) send_char(LF, 0);
            else begin
                send_char(CR, 0);
                send_char(LF, 0);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        wait_drain("drain_random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
